logic_unit_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle logic unit in the ALU datapath.
- Accepts operand pairs under a valid/ready handshake.
- Computes one of eight bitwise or shift functions.
- Delivers the result two cycles later with full backpressure support.
- Adds zero/valid flags and a wrap-around completed-operation counter for datapath debug and performance visibility.

---
 rtl/logic_unit_pkg.sv | 35 +++
 rtl/logic_unit_core.sv | 47 ++++
 rtl/logic_unit_pipe.sv | 179 +++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
//
// Shared definitions for the pipelined logic unit and any future unit that
// reuses the combinational core (e.g. the vector unit).
//
// Contents:
//   - Default width constants for data, function select and debug counter.
//   - Function-select encodings FUN_AND .. FUN_SHR.
//   - shamt_width(): number of b bits used as the shift amount.
// -----------------------------------------------------------------------------
package logic_unit_pkg;

    // Default widths.
    localparam int DATA_WIDTH_DEFAULT    = 16;
    localparam int ALU_FUN_WIDTH_DEFAULT = 3;
    localparam int CNT_WIDTH_DEFAULT     = 8;

    // Function-select encodings. The encoding is fixed at three bits.
    localparam logic [2:0] FUN_AND  = 3'b000;
    localparam logic [2:0] FUN_OR   = 3'b001;
    localparam logic [2:0] FUN_NAND = 3'b010;
    localparam logic [2:0] FUN_NOR  = 3'b011;
    localparam logic [2:0] FUN_XOR  = 3'b100;
    localparam logic [2:0] FUN_XNOR = 3'b101;
    localparam logic [2:0] FUN_SHL  = 3'b110;
    localparam logic [2:0] FUN_SHR  = 3'b111;

    // Width of the shift-amount field taken from the low bits of b.
    // A 1-bit datapath still needs a 1-bit field so the slice stays legal.
    function automatic int shamt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/logic_unit_core.sv
// -----------------------------------------------------------------------------
// logic_unit_core
//
// Purely combinational bitwise / shift function block. Holds no state so it
// can be dropped between any pair of pipeline registers.
//
// Ports:
//   a      [DATA_WIDTH-1:0]     operand A
//   b      [DATA_WIDTH-1:0]     operand B; low shamt_width() bits are the
//                               shift amount for shift functions
//   fun    [ALU_FUN_WIDTH-1:0]  function select (FUN_* encodings)
//   result [DATA_WIDTH-1:0]     function result, exactly DATA_WIDTH bits
// -----------------------------------------------------------------------------
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int ALU_FUN_WIDTH = ALU_FUN_WIDTH_DEFAULT
) (
    input  logic [DATA_WIDTH-1:0]    a,
    input  logic [DATA_WIDTH-1:0]    b,
    input  logic [ALU_FUN_WIDTH-1:0] fun,
    output logic [DATA_WIDTH-1:0]    result
);

    localparam int SHW = shamt_width(DATA_WIDTH);

    // Upper bits of b do not take part in shifts.
    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (fun)
            FUN_AND:  result = a & b;
            FUN_OR:   result = a | b;
            FUN_NAND: result = ~(a & b);
            FUN_NOR:  result = ~(a | b);
            FUN_XOR:  result = a ^ b;
            FUN_XNOR: result = ~(a ^ b);
            FUN_SHL:  result = a << shamt;   // logical, zero-fill
            FUN_SHR:  result = a >> shamt;   // logical, zero-fill
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//
// Two-stage pipelined logic unit with valid/ready handshaking on both sides,
// a registered zero flag and a wrap-around completed-operation counter.
//
//   S1: operand register (a, b, function) with valid bit v1
//   S2: result register (Logic_OUT, Zero_Flag) with valid bit v2
//
// Ports:
//   CLK           clock, all state changes on the rising edge
//   RST           asynchronous active-low reset
//   a, b          operands [DATA_WIDTH-1:0]
//   ALU_FUN       function select [ALU_FUN_WIDTH-1:0]
//   Logic_Enable  input valid
//   In_Ready      block can accept an operation this cycle
//   Logic_OUT     registered result [DATA_WIDTH-1:0]
//   Logic_Flag    output valid
//   Out_Ready     downstream accepts Logic_OUT this cycle
//   Zero_Flag     Logic_OUT == 0, qualified by Logic_Flag
//   Cnt_Clr       synchronous clear of Op_Count (wins over an increment)
//   Op_Count      output handshakes since reset/clear, modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int ALU_FUN_WIDTH = ALU_FUN_WIDTH_DEFAULT,
    parameter int CNT_WIDTH     = CNT_WIDTH_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    a,
    input  logic [DATA_WIDTH-1:0]    b,
    input  logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
    input  logic                     Logic_Enable,
    output logic                     In_Ready,
    output logic [DATA_WIDTH-1:0]    Logic_OUT,
    output logic                     Logic_Flag,
    input  logic                     Out_Ready,
    output logic                     Zero_Flag,
    input  logic                     Cnt_Clr,
    output logic [CNT_WIDTH-1:0]     Op_Count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    // S1 operand register
    logic [DATA_WIDTH-1:0]    a_q, a_d;
    logic [DATA_WIDTH-1:0]    b_q, b_d;
    logic [ALU_FUN_WIDTH-1:0] fun_q, fun_d;
    logic                     v1_q, v1_d;

    // S2 result register
    logic [DATA_WIDTH-1:0]    out_q, out_d;
    logic                     zero_q, zero_d;
    logic                     v2_q, v2_d;

    // Completed-operation counter
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

    // ---------------------------------------------------------------------
    // Handshake control
    // ---------------------------------------------------------------------
    logic adv1;     // S1 may load this cycle
    logic adv2;     // S2 may load this cycle
    logic out_hs;   // output handshake this cycle

    // Derived only from state and Out_Ready so that In_Ready never depends
    // combinationally on Logic_Enable.
    always_comb begin
        adv2   = !v2_q || Out_Ready;
        adv1   = !v1_q || adv2;
        out_hs = v2_q && Out_Ready;
    end

    // ---------------------------------------------------------------------
    // Function core between S1 and S2
    // ---------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] core_result;

    logic_unit_core #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ALU_FUN_WIDTH (ALU_FUN_WIDTH)
    ) u_core (
        .a      (a_q),
        .b      (b_q),
        .fun    (fun_q),
        .result (core_result)
    );

    // ---------------------------------------------------------------------
    // S1 next state
    // ---------------------------------------------------------------------
    // Operands are only captured on an accepted operation, so ALU_FUN or
    // operand changes while stalled have no effect.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        fun_d = fun_q;
        v1_d  = v1_q;
        if (adv1) begin
            v1_d = Logic_Enable;
            if (Logic_Enable) begin
                a_d   = a;
                b_d   = b;
                fun_d = ALU_FUN;
            end
        end
    end

    // ---------------------------------------------------------------------
    // S2 next state
    // ---------------------------------------------------------------------
    // A bubble moving into S2 clears the valid bit but leaves the result
    // and zero flag at their last values.
    always_comb begin
        out_d  = out_q;
        zero_d = zero_q;
        v2_d   = v2_q;
        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                out_d  = core_result;
                zero_d = (core_result == '0);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Counter next state
    // ---------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (Cnt_Clr) begin
            cnt_d = '0;
        end else if (out_hs) begin
            cnt_d = cnt_q + CNT_ONE;    // wraps naturally at 2^CNT_WIDTH
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_q    <= '0;
            b_q    <= '0;
            fun_q  <= '0;
            v1_q   <= 1'b0;
            out_q  <= '0;
            zero_q <= 1'b0;
            v2_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            fun_q  <= fun_d;
            v1_q   <= v1_d;
            out_q  <= out_d;
            zero_q <= zero_d;
            v2_q   <= v2_d;
            cnt_q  <= cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign In_Ready   = adv1;
    assign Logic_OUT  = out_q;
    assign Logic_Flag = v2_q;
    assign Zero_Flag  = zero_q;
    assign Op_Count   = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
//
// Directed, table-driven bench for logic_unit_pipe. Inputs change just after
// the falling edge; outputs are sampled 1 time unit later, well before the
// next rising edge. Accepted operations push their hand-computed result onto
// an expected queue which is popped on every output handshake.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    localparam int DW = 16;
    localparam int FW = 3;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [FW-1:0] ALU_FUN;
    logic          Logic_Enable;
    logic          In_Ready;
    logic [DW-1:0] Logic_OUT;
    logic          Logic_Flag;
    logic          Out_Ready;
    logic          Zero_Flag;
    logic          Cnt_Clr;
    logic [CW-1:0] Op_Count;

    logic_unit_pipe #(
        .DATA_WIDTH    (DW),
        .ALU_FUN_WIDTH (FW),
        .CNT_WIDTH     (CW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .a            (a),
        .b            (b),
        .ALU_FUN      (ALU_FUN),
        .Logic_Enable (Logic_Enable),
        .In_Ready     (In_Ready),
        .Logic_OUT    (Logic_OUT),
        .Logic_Flag   (Logic_Flag),
        .Out_Ready    (Out_Ready),
        .Zero_Flag    (Zero_Flag),
        .Cnt_Clr      (Cnt_Clr),
        .Op_Count     (Op_Count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [FW-1:0] fun;
        logic [DW-1:0] exp;
    } vec_t;

    int            total = 0;
    int            bad   = 0;
    int            outs_seen = 0;
    bit            hs_in;
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock cycle. Called right after a falling edge with inputs set.
    task automatic step(input logic [DW-1:0] exp_in);
        logic [DW-1:0] e;
        #1;
        hs_in = Logic_Enable && In_Ready;
        if (Logic_Flag && Out_Ready) begin
            outs_seen++;
            $display("out data=%h zero=%b cnt=%0d", Logic_OUT, Zero_Flag, Op_Count);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_extra: got %h want no output", Logic_OUT);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(Logic_OUT), 32'(e));
                check("out_zero", 32'(Zero_Flag), 32'(e == '0));
            end
        end
        if (hs_in) begin
            exp_q.push_back(exp_in);
            $display("in  a=%h b=%h fun=%0d exp=%h", a, b, ALU_FUN, exp_in);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drain(input int max, output int n);
        Logic_Enable = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            step('0);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send(input logic [DW-1:0] va, input logic [DW-1:0] vb,
                        input logic [FW-1:0] vf, input logic [DW-1:0] ve);
        a = va;
        b = vb;
        ALU_FUN = vf;
        Logic_Enable = 1'b1;
        step(ve);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        vec_t t3[5];
        int   n;
        int   idx;
        int   guard;

        vecs[0] = '{16'h00FF, 16'h0004, FUN_AND,  16'h0004};
        vecs[1] = '{16'h00FF, 16'h0004, FUN_OR,   16'h00FF};
        vecs[2] = '{16'h00FF, 16'h0004, FUN_NAND, 16'hFFFB};
        vecs[3] = '{16'h00FF, 16'h0004, FUN_NOR,  16'hFF00};
        vecs[4] = '{16'h00FF, 16'h0004, FUN_XOR,  16'h00FB};
        vecs[5] = '{16'h00FF, 16'h0004, FUN_XNOR, 16'hFF04};
        vecs[6] = '{16'h00FF, 16'h0004, FUN_SHL,  16'h0FF0};
        vecs[7] = '{16'h00FF, 16'h0004, FUN_SHR,  16'h000F};

        t3[0] = '{16'hFFFF, 16'h00FF, FUN_AND,  16'h00FF};
        t3[1] = '{16'h1200, 16'h0034, FUN_OR,   16'h1234};
        t3[2] = '{16'h0001, 16'h000F, FUN_SHL,  16'h8000};
        t3[3] = '{16'h8000, 16'h00F3, FUN_SHR,  16'h1000};  // upper b bits ignored
        t3[4] = '{16'hAAAA, 16'h5555, FUN_XNOR, 16'h0000};

        RST = 1'b0;
        a = '0;
        b = '0;
        ALU_FUN = '0;
        Logic_Enable = 1'b0;
        Out_Ready = 1'b0;
        Cnt_Clr = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        check("rst_in_ready", 32'(In_Ready), 32'd1);
        check("rst_flag",     32'(Logic_Flag), 32'd0);
        check("rst_out",      32'(Logic_OUT), 32'd0);
        check("rst_zero",     32'(Zero_Flag), 32'd0);
        check("rst_cnt",      32'(Op_Count), 32'd0);
        @(negedge CLK);
        RST = 1'b1;

        // 1: single XOR, latency 2
        Out_Ready = 1'b1;
        send(16'hF0F0, 16'h0FF0, FUN_XOR, 16'hFF00);
        check("t1_accept", 32'(hs_in), 32'd1);
        Logic_Enable = 1'b0;
        check("t1_flag_c1", 32'(Logic_Flag), 32'd0);
        step('0);
        check("t1_flag_c2", 32'(Logic_Flag), 32'd1);
        check("t1_out",     32'(Logic_OUT), 32'hFF00);
        check("t1_zero",    32'(Zero_Flag), 32'd0);
        step('0);
        check("t1_cnt",     32'(Op_Count), 32'd1);

        // 2: all functions back-to-back
        Cnt_Clr = 1'b1;
        step('0);
        Cnt_Clr = 1'b0;
        check("t2_cnt_clr", 32'(Op_Count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].exp);
            check("t2_accept", 32'(hs_in), 32'd1);
        end
        drain(20, n);
        check("t2_drain_cycles", 32'(n), 32'd2);
        check("t2_cnt", 32'(Op_Count), 32'd8);

        // 3: backpressure
        outs_seen = 0;
        send(t3[0].a, t3[0].b, t3[0].fun, t3[0].exp);
        send(t3[1].a, t3[1].b, t3[1].fun, t3[1].exp);
        check("t3_flag", 32'(Logic_Flag), 32'd1);
        check("t3_head", 32'(Logic_OUT), 32'h00FF);
        Out_Ready = 1'b0;
        a = t3[2].a;
        b = t3[2].b;
        ALU_FUN = t3[2].fun;
        for (int h = 0; h < 4; h++) begin
            step(t3[2].exp);
            check("t3_blocked",   32'(hs_in), 32'd0);
            check("t3_hold_data", 32'(Logic_OUT), 32'h00FF);
            check("t3_hold_flag", 32'(Logic_Flag), 32'd1);
            check("t3_hold_zero", 32'(Zero_Flag), 32'd0);
        end
        Out_Ready = 1'b1;
        idx = 2;
        guard = 0;
        while (idx < 5 && guard < 20) begin
            send(t3[idx].a, t3[idx].b, t3[idx].fun, t3[idx].exp);
            if (hs_in) idx++;
            guard++;
        end
        check("t3_all_sent", 32'(idx), 32'd5);
        drain(20, n);
        check("t3_out_count", 32'(outs_seen), 32'd5);

        // 4: zero flag
        send(16'h1234, 16'h1234, FUN_XOR, 16'h0000);
        Logic_Enable = 1'b0;
        step('0);
        check("t4_flag", 32'(Logic_Flag), 32'd1);
        check("t4_out",  32'(Logic_OUT), 32'd0);
        check("t4_zero", 32'(Zero_Flag), 32'd1);
        step('0);

        // 5: counter wrap, then clear during a handshake
        Cnt_Clr = 1'b1;
        step('0);
        Cnt_Clr = 1'b0;
        outs_seen = 0;
        for (int i = 0; i < 256; i++) begin
            send(i[DW-1:0], 16'h0000, FUN_OR, i[DW-1:0]);
        end
        drain(20, n);
        check("t5_outs", 32'(outs_seen), 32'd256);
        check("t5_wrap", 32'(Op_Count), 32'd0);
        send(16'h0F0F, 16'h0000, FUN_OR, 16'h0F0F);
        Logic_Enable = 1'b0;
        step('0);
        check("t5_flag", 32'(Logic_Flag), 32'd1);
        Cnt_Clr = 1'b1;
        step('0);
        Cnt_Clr = 1'b0;
        check("t5_clr_priority", 32'(Op_Count), 32'd0);

        // 6: reset with both stages full
        send(16'hFFFF, 16'h0000, FUN_OR, 16'hFFFF);
        drain(20, n);
        check("t6_pre_cnt", 32'(Op_Count), 32'd1);
        Out_Ready = 1'b0;
        send(16'h00F0, 16'h0F00, FUN_OR, 16'h0FF0);
        send(16'h0001, 16'h0003, FUN_SHL, 16'h0008);
        Logic_Enable = 1'b0;
        #1;
        check("t6_full_flag", 32'(Logic_Flag), 32'd1);
        check("t6_full_out",  32'(Logic_OUT), 32'h0FF0);
        check("t6_full_rdy",  32'(In_Ready), 32'd0);
        #1;
        RST = 1'b0;
        #1;
        check("t6_rst_flag", 32'(Logic_Flag), 32'd0);
        check("t6_rst_out",  32'(Logic_OUT), 32'd0);
        check("t6_rst_zero", 32'(Zero_Flag), 32'd0);
        check("t6_rst_cnt",  32'(Op_Count), 32'd0);
        check("t6_rst_rdy",  32'(In_Ready), 32'd1);
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b1;
        Out_Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step('0);
            check("t6_no_stale", 32'(Logic_Flag), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
